// File: rtl/mxu_sequencer_pkg.sv
// mxu_sequencer_pkg: shared FSM state type and default sizing for the matmul sequencer
package mxu_sequencer_pkg;
  localparam int DEF_NUM_SIZE = 16;
  localparam int DEF_GRID = 4;
  localparam int DEF_ADDR_W = 8;
  typedef enum logic [2:0] {IDLE, LOAD, FEED, WRITE, DONE} state_t;
endpackage

// File: rtl/mxu_grid.sv
// mxu_grid: output-stationary systolic array; A flows east, B flows south, each PE accumulates
module mxu_grid
  import mxu_sequencer_pkg::*;
#(
  parameter int NUM_SIZE = DEF_NUM_SIZE,
  parameter int GRID = DEF_GRID
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ce,
  input  logic                          clr,
  input  logic [GRID*NUM_SIZE-1:0]      north_input,
  input  logic [GRID*NUM_SIZE-1:0]      west_input,
  output logic [GRID*GRID*NUM_SIZE-1:0] result_out
);
  for (genvar i = 0; i < GRID; i++) begin : row
    for (genvar j = 0; j < GRID; j++) begin : col
      logic [NUM_SIZE-1:0] a_in, b_in, a_r, b_r, acc_r;
      if (j == 0) begin : w_edge
        assign a_in = west_input[i*NUM_SIZE +: NUM_SIZE];
      end else begin : w_pass
        assign a_in = row[i].col[j-1].a_r;
      end
      if (i == 0) begin : n_edge
        assign b_in = north_input[j*NUM_SIZE +: NUM_SIZE];
      end else begin : n_pass
        assign b_in = row[i-1].col[j].b_r;
      end
      // forward operands one hop per enabled cycle and accumulate their product modulo 2^NUM_SIZE
      always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
          a_r <= '0;
          b_r <= '0;
          acc_r <= '0;
        end else if (ce) begin
          a_r <= a_in;
          b_r <= b_in;
          acc_r <= acc_r + a_in * b_in;
        end
      end
      assign result_out[(i*GRID+j)*NUM_SIZE +: NUM_SIZE] = acc_r;
    end
  end
endmodule

// File: rtl/mxu_sequencer.sv
// mxu_sequencer: loads A/B from scratch memory, streams them through mxu_grid, writes C back
module mxu_sequencer
  import mxu_sequencer_pkg::*;
#(
  parameter int NUM_SIZE = DEF_NUM_SIZE,
  parameter int GRID = DEF_GRID,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_a,
  input  logic [ADDR_W-1:0]   src_b,
  input  logic [ADDR_W-1:0]   dst,
  output logic [ADDR_W-1:0]   rd_a_addr,
  input  logic [NUM_SIZE-1:0] rd_a_data,
  output logic [ADDR_W-1:0]   rd_b_addr,
  input  logic [NUM_SIZE-1:0] rd_b_data,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_SIZE-1:0] wr_data,
  output logic                busy,
  output logic                done
);
  localparam int N = GRID * GRID;
  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST_LOAD = CW'(N);
  localparam logic [CW-1:0] LAST_FEED = CW'(3 * GRID - 3);
  localparam logic [CW-1:0] LAST_WRITE = CW'(N - 1);
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [ADDR_W-1:0] a_base, b_base, d_base;
  logic [NUM_SIZE-1:0] a_buf [N];
  logic [NUM_SIZE-1:0] b_buf [N];
  logic [GRID*NUM_SIZE-1:0] north, west;
  logic [N*NUM_SIZE-1:0] result;
  logic last, ce, clr;
  assign last = cnt == (state == LOAD ? LAST_LOAD : state == FEED ? LAST_FEED : LAST_WRITE);
  assign ce = state == FEED;
  assign clr = state == IDLE && start;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign wr_en = state == WRITE;
  assign rd_a_addr = state == LOAD ? a_base + ADDR_W'(cnt) : '0;
  assign rd_b_addr = state == LOAD ? b_base + ADDR_W'(cnt) : '0;
  assign wr_addr = wr_en ? d_base + ADDR_W'(cnt) : '0;
  // phase sequencing: each busy phase ends when its cycle counter reaches its last index
  always_comb begin
    next_state = state;
    if (state == IDLE) next_state = start ? LOAD : IDLE;
    else if (state == DONE) next_state = IDLE;
    else if (last) next_state = state == LOAD ? FEED : state == FEED ? WRITE : DONE;
  end
  // state, phase counter and base addresses captured at launch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      a_base <= '0;
      b_base <= '0;
      d_base <= '0;
    end else begin
      state <= next_state;
      cnt <= (state == IDLE || state == DONE || last) ? '0 : cnt + 1'b1;
      if (clr) begin
        a_base <= src_a;
        b_base <= src_b;
        d_base <= dst;
      end
    end
  end
  // read data lags its address by one cycle, so word k lands while the counter shows k+1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        a_buf[k] <= '0;
        b_buf[k] <= '0;
      end
    end else if (state == LOAD) begin
      for (int k = 0; k < N; k++) begin
        if (cnt == CW'(k + 1)) begin
          a_buf[k] <= rd_a_data;
          b_buf[k] <= rd_b_data;
        end
      end
    end
  end
  // skewed edge feed: row i gets A[i][t-i], column j gets B[t-j][j], zero outside the matrix
  always_comb begin
    west = '0;
    north = '0;
    for (int i = 0; i < GRID; i++) begin
      for (int k = 0; k < GRID; k++) begin
        if (state == FEED && cnt == CW'(i + k)) begin
          west[i*NUM_SIZE +: NUM_SIZE] = a_buf[i*GRID+k];
          north[i*NUM_SIZE +: NUM_SIZE] = b_buf[k*GRID+i];
        end
      end
    end
  end
  // row-major result word selected by the write counter
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < N; k++) begin
      if (wr_en && cnt == CW'(k)) wr_data = result[k*NUM_SIZE +: NUM_SIZE];
    end
  end
  mxu_grid #(.NUM_SIZE(NUM_SIZE), .GRID(GRID)) u_grid (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .clr(clr),
    .north_input(north),
    .west_input(west),
    .result_out(result)
  );
endmodule
